// File: rtl/load_store_unit.sv
// load_store_unit
//
// Bridges the execute stage and a byte-addressed, big-endian 16-bit data
// memory. One load or store is accepted per handshake. Word and byte accesses
// are supported; byte loads are sign- or zero-extended, and byte stores are
// done as read-modify-write of the containing word. Out-of-range addresses
// complete immediately with a fault and never touch the memory.
//
// Ports:
//   Clock, Reset              clock and synchronous active-high reset
//   ReqValid / ReqReady       request handshake (ready only in IDLE)
//   ReqWrite, ReqByte         store/load and byte/word select
//   ReqSigned                 sign-extend byte loads
//   ReqAddr, ReqWData         byte address and store data
//   RespValid                 one-cycle completion pulse
//   RespData, RespFault       load result and out-of-range flag
//   MemAddress, MemWriteData  memory address and big-endian write word
//   MemWrite, MemRead         memory strobes (never both high)
//   MemReadData               combinational memory read word

module load_store_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqByte,
  input  logic        ReqSigned,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        RespValid,
  output logic [15:0] RespData,
  output logic        RespFault,
  output logic [15:0] MemAddress,
  output logic [15:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [15:0] MemReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  localparam logic [15:0] LAST_BYTE = 16'(MEM_BYTES - 1);
  localparam logic [15:0] LAST_WORD = 16'(MEM_BYTES - 2);

  state_t      state, next_state;
  logic        is_write, is_byte, is_signed, is_fault, sel_high;
  logic [15:0] window, wdata, hold_word;

  logic        handshake;
  logic        req_fault;
  logic        req_at_top;
  logic [7:0]  sel_byte;
  logic [15:0] load_value;
  logic [15:0] merged_word;

  // Request decode. A byte access to the very last byte cannot use a word
  // window starting at its own address (that would run off the end), so the
  // window slides down by one and the wanted byte becomes the low byte.
  always_comb begin
    handshake  = ReqValid && (state == IDLE);
    req_at_top = ReqByte && (ReqAddr == LAST_BYTE);
    req_fault  = ReqByte ? (ReqAddr > LAST_BYTE) : (ReqAddr > LAST_WORD);
  end

  // Byte extraction/extension for loads and byte replacement for stores.
  always_comb begin
    sel_byte    = sel_high ? MemReadData[15:8] : MemReadData[7:0];
    load_value  = MemReadData;
    if (is_byte) begin
      load_value = {((is_signed && sel_byte[7]) ? 8'hFF : 8'h00), sel_byte};
    end
    merged_word = sel_high ? {wdata[7:0], hold_word[7:0]}
                           : {hold_word[15:8], wdata[7:0]};
  end

  // State register plus the request fields latched on the handshake and the
  // word captured during ACCESS (load result, or the old word for a merge).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      is_byte   <= 1'b0;
      is_signed <= 1'b0;
      is_fault  <= 1'b0;
      sel_high  <= 1'b0;
      window    <= 16'h0000;
      wdata     <= 16'h0000;
      hold_word <= 16'h0000;
    end else begin
      state <= next_state;
      if (handshake) begin
        is_write  <= ReqWrite;
        is_byte   <= ReqByte;
        is_signed <= ReqSigned;
        is_fault  <= req_fault;
        sel_high  <= !req_at_top;
        window    <= req_at_top ? (ReqAddr - 16'd1) : ReqAddr;
        wdata     <= ReqWData;
      end
      if (state == ACCESS) begin
        hold_word <= is_write ? MemReadData : load_value;
      end
    end
  end

  // Next-state and output decode. Everything is forced low while Reset is
  // high so that an aborted byte store cannot complete its write on the
  // same edge that resets the state.
  always_comb begin
    next_state   = state;
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    RespData     = 16'h0000;
    RespFault    = 1'b0;
    MemAddress   = 16'h0000;
    MemWriteData = 16'h0000;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          next_state = req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        MemAddress = window;
        if (is_write && !is_byte) begin
          MemWrite     = 1'b1;
          MemWriteData = wdata;
          next_state   = RESP;
        end else begin
          MemRead    = 1'b1;
          next_state = is_write ? MERGE : RESP;
        end
      end
      MERGE: begin
        MemWrite     = 1'b1;
        MemAddress   = window;
        MemWriteData = merged_word;
        next_state   = RESP;
      end
      RESP: begin
        RespValid  = 1'b1;
        RespFault  = is_fault;
        RespData   = (is_fault || is_write) ? 16'h0000 : hold_word;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (Reset) begin
      ReqReady     = 1'b0;
      RespValid    = 1'b0;
      RespData     = 16'h0000;
      RespFault    = 1'b0;
      MemAddress   = 16'h0000;
      MemWriteData = 16'h0000;
      MemWrite     = 1'b0;
      MemRead      = 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Directed bench for load_store_unit with a 128-byte big-endian memory model.
// Each step issues one request and checks strobes and responses cycle by
// cycle against hand-computed values.

module tb_load_store_unit;

  logic        Clock;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqByte;
  logic        ReqSigned;
  logic [15:0] ReqAddr;
  logic [15:0] ReqWData;
  logic        RespValid;
  logic [15:0] RespData;
  logic        RespFault;
  logic [15:0] MemAddress;
  logic [15:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] MemReadData;

  logic [7:0]  mem [0:127];
  logic        preload;
  int          tests_run;
  int          fail_count;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqByte      (ReqByte),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .RespValid    (RespValid),
    .RespData     (RespData),
    .RespFault    (RespFault),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  // Free-running clock, 10 time units per cycle.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: preload known contents, otherwise write on the rising edge.
  always @(posedge Clock) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem[7]   <= 8'h80;
      mem[10]  <= 8'h12;
      mem[11]  <= 8'h34;
      mem[126] <= 8'h11;
    end else if (MemWrite && MemAddress < 16'd127) begin
      mem[int'(MemAddress)]     <= MemWriteData[15:8];
      mem[int'(MemAddress) + 1] <= MemWriteData[7:0];
    end
  end

  // Combinational big-endian read of the word at MemAddress.
  always_comb begin
    MemReadData = 16'h0000;
    if (MemAddress < 16'd127) begin
      MemReadData = {mem[int'(MemAddress)], mem[int'(MemAddress) + 1]};
    end
  end

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one request at the falling edge; returns #1 after the handshake
  // edge, i.e. in the first cycle after the handshake.
  task automatic apply_stimulus(input logic wr, input logic by, input logic sg,
                                input logic [15:0] addr, input logic [15:0] wd);
    @(negedge Clock);
    ReqWrite  = wr;
    ReqByte   = by;
    ReqSigned = sg;
    ReqAddr   = addr;
    ReqWData  = wd;
    ReqValid  = 1'b1;
    check_output("ready_at_issue", 16'(ReqReady), 16'h1);
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    Reset      = 1'b1;
    preload    = 1'b1;
    ReqValid   = 1'b0;
    ReqWrite   = 1'b0;
    ReqByte    = 1'b0;
    ReqSigned  = 1'b0;
    ReqAddr    = 16'h0000;
    ReqWData   = 16'h0000;

    // Reset: all outputs low while held.
    repeat (2) step();
    preload = 1'b0;
    check_output("rst_memread", 16'(MemRead), 16'h0);
    check_output("rst_memwrite", 16'(MemWrite), 16'h0);
    check_output("rst_respvalid", 16'(RespValid), 16'h0);
    check_output("rst_memaddr", MemAddress, 16'h0000);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check_output("rst_ready_after", 16'(ReqReady), 16'h1);

    // Word store 0xBEEF to 4.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd4, 16'hBEEF);
    check_output("wst_memwrite", 16'(MemWrite), 16'h1);
    check_output("wst_memread", 16'(MemRead), 16'h0);
    check_output("wst_addr", MemAddress, 16'd4);
    check_output("wst_wdata", MemWriteData, 16'hBEEF);
    check_output("wst_no_resp_n1", 16'(RespValid), 16'h0);
    step();
    check_output("wst_resp", 16'(RespValid), 16'h1);
    check_output("wst_respdata", RespData, 16'h0000);
    check_output("wst_strobe_off", 16'(MemWrite), 16'h0);
    step();
    check_output("wst_resp_pulse", 16'(RespValid), 16'h0);

    // Word load from 4, back to back.
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd4, 16'h0000);
    check_output("wld_memread", 16'(MemRead), 16'h1);
    check_output("wld_addr", MemAddress, 16'd4);
    check_output("wld_wdata_zero", MemWriteData, 16'h0000);
    step();
    check_output("wld_resp", 16'(RespValid), 16'h1);
    check_output("wld_data", RespData, 16'hBEEF);
    check_output("wld_fault", 16'(RespFault), 16'h0);
    step();
    check_output("wld_data_idle", RespData, 16'h0000);

    // Byte store 0xAB to 10 (old word 0x1234).
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'd10, 16'h00AB);
    check_output("bst_read", 16'(MemRead), 16'h1);
    check_output("bst_read_nowrite", 16'(MemWrite), 16'h0);
    check_output("bst_read_addr", MemAddress, 16'd10);
    step();
    check_output("bst_write", 16'(MemWrite), 16'h1);
    check_output("bst_write_noread", 16'(MemRead), 16'h0);
    check_output("bst_write_addr", MemAddress, 16'd10);
    check_output("bst_write_data", MemWriteData, 16'hAB34);
    check_output("bst_no_resp_n2", 16'(RespValid), 16'h0);
    step();
    check_output("bst_resp", 16'(RespValid), 16'h1);
    check_output("bst_respdata", RespData, 16'h0000);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd10, 16'h0000);
    step();
    check_output("bst_readback", RespData, 16'hAB34);
    step();

    // Byte loads from 7 (0x80), signed and unsigned.
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'd7, 16'h0000);
    check_output("bld_addr", MemAddress, 16'd7);
    step();
    check_output("bld_signed", RespData, 16'hFF80);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'd7, 16'h0000);
    step();
    check_output("bld_unsigned", RespData, 16'h0080);
    step();

    // Byte store 0x5A to the last byte: window slides to 126.
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'd127, 16'h005A);
    check_output("top_read_addr", MemAddress, 16'd126);
    step();
    check_output("top_write_addr", MemAddress, 16'd126);
    check_output("top_write_data", MemWriteData, 16'h115A);
    step();
    check_output("top_resp", 16'(RespValid), 16'h1);
    step();
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'd127, 16'h0000);
    step();
    check_output("top_byte_load", RespData, 16'h005A);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd126, 16'h0000);
    step();
    check_output("top_word_load126", RespData, 16'h115A);
    step();

    // Faults: word load from 127, byte load from 200.
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd127, 16'h0000);
    check_output("fw_resp", 16'(RespValid), 16'h1);
    check_output("fw_fault", 16'(RespFault), 16'h1);
    check_output("fw_data", RespData, 16'h0000);
    check_output("fw_memread", 16'(MemRead), 16'h0);
    check_output("fw_memwrite", 16'(MemWrite), 16'h0);
    step();
    check_output("fw_fault_idle", 16'(RespFault), 16'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'd200, 16'h0000);
    check_output("fb_resp", 16'(RespValid), 16'h1);
    check_output("fb_fault", 16'(RespFault), 16'h1);
    check_output("fb_data", RespData, 16'h0000);
    check_output("fb_memread", 16'(MemRead), 16'h0);
    check_output("fb_memwrite", 16'(MemWrite), 16'h0);
    step();

    // Reset during MERGE of a byte store 0x77 to 10: no write, no response.
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'd10, 16'h0077);
    step();
    Reset = 1'b1;
    #1;
    check_output("abort_no_write", 16'(MemWrite), 16'h0);
    check_output("abort_no_resp", 16'(RespValid), 16'h0);
    step();
    Reset = 1'b0;
    #1;
    check_output("abort_ready", 16'(ReqReady), 16'h1);
    check_output("abort_write_after", 16'(MemWrite), 16'h0);
    check_output("abort_resp_after", 16'(RespValid), 16'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'd10, 16'h0000);
    step();
    check_output("abort_mem_intact", RespData, 16'hAB34);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
